// File: rtl/spi_sink_pkg.sv
// Shared types and constants for the SPI register-file sink.
package spi_sink_pkg;

    typedef enum logic [2:0] {
        IDLE,
        OPCODE,
        ADDR,
        WRITE,
        READ,
        IGNORE
    } spi_sink_state_t;

    localparam logic [3:0] OPC_BASE_DEF = 4'b0100;
    localparam logic [7:0] REG_IODIRA   = 8'h00;
    localparam logic [7:0] REG_IODIRB   = 8'h01;
    localparam logic [7:0] REG_GPIOA    = 8'h12;
    localparam logic [7:0] REG_GPIOB    = 8'h13;

    function automatic logic in_range(input logic [7:0] a, input int n);
        return int'(a) < n;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for one asynchronous input plus single-cycle edge pulses.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              last_q;

    // Resets low so a CSN held low across reset never produces a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            last_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~last_q;
    assign fall  = ~level & last_q;

endmodule

// File: rtl/spi_regfile_sink.sv
// SPI mode-0 target emulating an MCP23S17-style register file with a fabric host port.
// Build option: define SPI_HW_ADDR_EN to require opcode bits [3:1] to match hw_addr_i.
//
// state  | meaning
// IDLE   | waiting for CSN falling edge
// OPCODE | shifting in the opcode byte
// ADDR   | shifting in the register address byte
// WRITE  | shifting in data bytes, writing each completed byte
// READ   | shifting out register bytes on SCLK falling edges
// IGNORE | frame rejected, waiting for CSN rising edge
module spi_regfile_sink
    import spi_sink_pkg::*;
#(
    parameter int         NUM_REGS    = 22,
    parameter int         SYNC_STAGES = 2,
    parameter int         SEQ_EN      = 1,
    parameter logic [3:0] OPC_BASE    = OPC_BASE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk_i,
    input  logic       csn_i,
    input  logic       mosi_i,
    output logic       miso_o,
    output logic       miso_oe_o,
    input  logic [2:0] hw_addr_i,
    input  logic [7:0] host_addr_i,
    input  logic       host_we_i,
    input  logic [7:0] host_wdata_i,
    output logic [7:0] host_rdata_o,
    output logic       wr_stb_o,
    output logic [7:0] wr_addr_o,
    output logic [7:0] wr_data_o,
    output logic       busy_o
);

    localparam int         AW   = $clog2(NUM_REGS);
    localparam logic [7:0] LAST = 8'(NUM_REGS - 1);

    logic sclk_rise, sclk_fall, sclk_lvl_unused;
    logic csn_rise, csn_fall, csn_lvl_unused;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst(rst), .din(sclk_i),
        .level(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_csn (
        .clk(clk), .rst(rst), .din(csn_i),
        .level(csn_lvl_unused), .rise(csn_rise), .fall(csn_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .rst(rst), .din(mosi_i),
        .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    spi_sink_state_t state;
    logic [2:0] bit_cnt;
    logic [6:0] shift_in;
    logic [7:0] shift_out;
    logic [7:0] ptr;
    logic [7:0] ptr_nxt;
    logic       opc_rd;
    logic       opc_ok;
    logic [7:0] rx_byte;
    logic [7:0] rd_rx;
    logic [7:0] rd_nxt;
    logic       spi_we;
    logic [7:0] regs [NUM_REGS];

    assign rx_byte = {shift_in, mosi_s};

`ifdef SPI_HW_ADDR_EN
    assign opc_ok = (rx_byte[7:4] == OPC_BASE) && (rx_byte[3:1] == hw_addr_i);
`else
    logic hw_addr_unused;
    assign hw_addr_unused = ^hw_addr_i;
    assign opc_ok = (rx_byte[7:4] == OPC_BASE);
`endif

    always_comb begin
        ptr_nxt = ptr;
        if (SEQ_EN != 0 && in_range(ptr, NUM_REGS))
            ptr_nxt = (ptr == LAST) ? 8'd0 : ptr + 8'd1;
    end

    always_comb begin
        rd_rx  = 8'h00;
        rd_nxt = 8'h00;
        if (in_range(rx_byte, NUM_REGS)) rd_rx  = regs[rx_byte[AW-1:0]];
        if (in_range(ptr_nxt, NUM_REGS)) rd_nxt = regs[ptr_nxt[AW-1:0]];
    end

    assign spi_we = (state == WRITE) && sclk_rise && !csn_rise && (bit_cnt == 3'd0)
                    && in_range(ptr, NUM_REGS);

    // SPI write is placed after the host write so it wins on a same-register collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= (i == int'(REG_IODIRA) || i == int'(REG_IODIRB)) ? 8'hFF : 8'h00;
        end else begin
            if (host_we_i && in_range(host_addr_i, NUM_REGS))
                regs[host_addr_i[AW-1:0]] <= host_wdata_i;
            if (spi_we)
                regs[ptr[AW-1:0]] <= rx_byte;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            host_rdata_o <= 8'h00;
        end else begin
            host_rdata_o <= in_range(host_addr_i, NUM_REGS) ? regs[host_addr_i[AW-1:0]] : 8'h00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= 3'd7;
            shift_in  <= '0;
            shift_out <= '0;
            ptr       <= '0;
            opc_rd    <= 1'b0;
            miso_o    <= 1'b0;
            miso_oe_o <= 1'b0;
            busy_o    <= 1'b0;
            wr_stb_o  <= 1'b0;
            wr_addr_o <= '0;
            wr_data_o <= '0;
        end else begin
            wr_stb_o <= 1'b0;
            if (csn_rise) begin
                state     <= IDLE;
                bit_cnt   <= 3'd7;
                miso_o    <= 1'b0;
                miso_oe_o <= 1'b0;
                busy_o    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (csn_fall) begin
                            state   <= OPCODE;
                            bit_cnt <= 3'd7;
                        end
                    end
                    OPCODE: begin
                        if (sclk_rise) begin
                            shift_in <= rx_byte[6:0];
                            bit_cnt  <= bit_cnt - 3'd1;
                            if (bit_cnt == 3'd0) begin
                                if (opc_ok) begin
                                    state  <= ADDR;
                                    busy_o <= 1'b1;
                                    opc_rd <= rx_byte[0];
                                end else begin
                                    state <= IGNORE;
                                end
                            end
                        end
                    end
                    ADDR: begin
                        if (sclk_rise) begin
                            shift_in <= rx_byte[6:0];
                            bit_cnt  <= bit_cnt - 3'd1;
                            if (bit_cnt == 3'd0) begin
                                ptr <= rx_byte;
                                if (opc_rd) begin
                                    shift_out <= rd_rx;
                                    miso_oe_o <= 1'b1;
                                    state     <= READ;
                                end else begin
                                    state <= WRITE;
                                end
                            end
                        end
                    end
                    WRITE: begin
                        if (sclk_rise) begin
                            shift_in <= rx_byte[6:0];
                            bit_cnt  <= bit_cnt - 3'd1;
                            if (bit_cnt == 3'd0) begin
                                if (in_range(ptr, NUM_REGS)) begin
                                    wr_stb_o  <= 1'b1;
                                    wr_addr_o <= ptr;
                                    wr_data_o <= rx_byte;
                                end
                                ptr <= ptr_nxt;
                            end
                        end
                    end
                    READ: begin
                        if (sclk_fall) begin
                            miso_o  <= shift_out[7];
                            bit_cnt <= bit_cnt - 3'd1;
                            if (bit_cnt == 3'd0) begin
                                ptr       <= ptr_nxt;
                                shift_out <= rd_nxt;
                            end else begin
                                shift_out <= {shift_out[6:0], 1'b0};
                            end
                        end
                    end
                    IGNORE: begin
                        miso_oe_o <= 1'b0;
                        busy_o    <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_regfile_sink.sv
// Directed bench for spi_regfile_sink: register file access over SPI and the host port.
module tb_spi_regfile_sink;
    localparam int HALF = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sclk_i = 1'b0;
    logic       csn_i = 1'b1;
    logic       mosi_i = 1'b0;
    logic       miso_o, miso_oe_o;
    logic [2:0] hw_addr_i = 3'b010;
    logic [7:0] host_addr_i = 8'h00;
    logic       host_we_i = 1'b0;
    logic [7:0] host_wdata_i = 8'h00;
    logic [7:0] host_rdata_o;
    logic       wr_stb_o;
    logic [7:0] wr_addr_o, wr_data_o;
    logic       busy_o;

    spi_regfile_sink dut (
        .clk(clk), .rst(rst), .sclk_i(sclk_i), .csn_i(csn_i), .mosi_i(mosi_i),
        .miso_o(miso_o), .miso_oe_o(miso_oe_o), .hw_addr_i(hw_addr_i),
        .host_addr_i(host_addr_i), .host_we_i(host_we_i), .host_wdata_i(host_wdata_i),
        .host_rdata_o(host_rdata_o), .wr_stb_o(wr_stb_o), .wr_addr_o(wr_addr_o),
        .wr_data_o(wr_data_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int stb_cnt = 0;
    logic [7:0] stb_addr = 8'h00;
    logic [7:0] stb_data = 8'h00;

    logic [7:0] tx [0:3];
    logic [7:0] rx [0:3];
    logic       oe_log   [0:31];
    logic       busy_log [0:31];
    logic [7:0] rd;

    always @(negedge clk) begin
        if (wr_stb_o) begin
            stb_cnt++;
            stb_addr = wr_addr_o;
            stb_data = wr_data_o;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic host_rd(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk) host_addr_i = a;
        @(negedge clk) d = host_rdata_o;
    endtask

    task automatic host_wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        host_addr_i  = a;
        host_wdata_i = d;
        host_we_i    = 1'b1;
        @(negedge clk) host_we_i = 1'b0;
    endtask

    // Clocks nbits MSB-first from tx[], sampling MISO/OE/BUSY just before each rising SCLK.
    task automatic spi_xfer(input int nbits, input bit raise_cs);
        if (csn_i) begin
            csn_i = 1'b0;
            #HALF;
        end
        for (int k = 0; k < nbits; k++) begin
            mosi_i = tx[k/8][7-(k%8)];
            #HALF;
            rx[k/8][7-(k%8)] = miso_o;
            oe_log[k]   = miso_oe_o;
            busy_log[k] = busy_o;
            sclk_i = 1'b1;
            #HALF;
            sclk_i = 1'b0;
        end
        if (raise_cs) begin
            #HALF;
            csn_i = 1'b1;
            #(4*HALF);
        end
    endtask

    initial begin
        int  s0;
        logic any_oe;
        logic all_oe;

        for (int k = 0; k < 32; k++) begin
            oe_log[k] = 1'b0;
            busy_log[k] = 1'b0;
        end
        for (int k = 0; k < 4; k++) rx[k] = 8'h00;

        // Reset state
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_miso", miso_o, 0);
        check("rst_oe", miso_oe_o, 0);
        check("rst_stb", wr_stb_o, 0);
        check("rst_waddr", wr_addr_o, 0);
        check("rst_wdata", wr_data_o, 0);
        check("rst_hrdata", host_rdata_o, 0);
        check("rst_busy", busy_o, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        host_rd(8'h00, rd); check("rst_reg00", rd, 8'hFF);
        host_rd(8'h01, rd); check("rst_reg01", rd, 8'hFF);
        host_rd(8'h05, rd); check("rst_reg05", rd, 8'h00);

        // Plain write frame
        s0 = stb_cnt;
        tx[0] = 8'h44; tx[1] = 8'h12; tx[2] = 8'hA5;
        spi_xfer(24, 1);
        check("wr_stb_cnt", stb_cnt - s0, 1);
        check("wr_addr", stb_addr, 8'h12);
        check("wr_data", stb_data, 8'hA5);
        check("wr_busy_mid", busy_log[20], 1);
        check("wr_busy_end", busy_o, 0);
        host_rd(8'h12, rd); check("wr_reg12", rd, 8'hA5);

`ifndef SPI_HW_ADDR_EN
        tx[0] = 8'h40; tx[1] = 8'h13; tx[2] = 8'h5E;
        spi_xfer(24, 1);
        host_rd(8'h13, rd); check("wr40_reg13", rd, 8'h5E);
`endif

        // Sequential read of host-preloaded bytes
        host_wr(8'h14, 8'h3C);
        host_wr(8'h15, 8'hC3);
        tx[0] = 8'h45; tx[1] = 8'h14; tx[2] = 8'h00; tx[3] = 8'h00;
        spi_xfer(32, 1);
        check("rd_byte0", rx[2], 8'h3C);
        check("rd_byte1", rx[3], 8'hC3);
        any_oe = 1'b0;
        all_oe = 1'b1;
        for (int k = 0; k < 16; k++) any_oe |= oe_log[k];
        for (int k = 16; k < 32; k++) all_oe &= oe_log[k];
        check("rd_oe_hdr", any_oe, 0);
        check("rd_oe_data", all_oe, 1);
        check("rd_oe_end", miso_oe_o, 0);
        check("rd_miso_end", miso_o, 0);

        // Address wrap at NUM_REGS-1
        s0 = stb_cnt;
        tx[0] = 8'h44; tx[1] = 8'h15; tx[2] = 8'h11; tx[3] = 8'h22;
        spi_xfer(32, 1);
        check("wrap_stb_cnt", stb_cnt - s0, 2);
        host_rd(8'h15, rd); check("wrap_reg15", rd, 8'h11);
        host_rd(8'h00, rd); check("wrap_reg00", rd, 8'h22);

        // Rejected opcode
        s0 = stb_cnt;
`ifdef SPI_HW_ADDR_EN
        tx[0] = 8'h40;
`else
        tx[0] = 8'h24;
`endif
        tx[1] = 8'h03; tx[2] = 8'h77;
        spi_xfer(24, 1);
        check("ign_stb_cnt", stb_cnt - s0, 0);
        check("ign_busy", busy_log[20], 0);
        check("ign_oe", oe_log[20], 0);
        host_rd(8'h03, rd); check("ign_reg03", rd, 8'h00);

        // Out-of-range SPI write/read and host write
        s0 = stb_cnt;
        tx[0] = 8'h44; tx[1] = 8'h20; tx[2] = 8'h5A;
        spi_xfer(24, 1);
        check("oor_stb_cnt", stb_cnt - s0, 0);
        tx[0] = 8'h45; tx[1] = 8'h20; tx[2] = 8'h00;
        spi_xfer(24, 1);
        check("oor_rd", rx[2], 8'h00);
        host_wr(8'h30, 8'h99);
        host_rd(8'h30, rd); check("oor_host", rd, 8'h00);

        // CSN raised after 5 data bits
        s0 = stb_cnt;
        tx[0] = 8'h44; tx[1] = 8'h07; tx[2] = 8'hFF;
        spi_xfer(21, 1);
        check("part_stb_cnt", stb_cnt - s0, 0);
        check("part_busy", busy_o, 0);
        host_rd(8'h07, rd); check("part_reg07", rd, 8'h00);

        // Reset mid-read, CSN still low across release
        tx[0] = 8'h45; tx[1] = 8'h14; tx[2] = 8'h00;
        spi_xfer(20, 0);
        check("mid_oe_pre", miso_oe_o, 1);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        check("mid_rst_oe", miso_oe_o, 0);
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_miso", miso_o, 0);
        @(negedge clk) rst = 1'b0;
        s0 = stb_cnt;
        tx[0] = 8'h44; tx[1] = 8'h09; tx[2] = 8'h66;
        spi_xfer(24, 1);
        check("post_rst_stb", stb_cnt - s0, 0);
        host_rd(8'h09, rd); check("post_rst_reg09", rd, 8'h00);
        host_rd(8'h14, rd); check("post_rst_reg14", rd, 8'h00);
        host_rd(8'h00, rd); check("post_rst_reg00", rd, 8'hFF);
        spi_xfer(24, 1);
        check("recov_stb", stb_cnt - s0, 1);
        host_rd(8'h09, rd); check("recov_reg09", rd, 8'h66);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_regfile_sink.md
Name: spi_regfile_sink

Overview:
- Parametrised SPI target (mode 0) that emulates an MCP23S17-style register file.
- Oversamples SCLK/CSN/MOSI on the fabric clock.
- Decodes opcode/address/data frames and supports multi-byte sequential reads and writes with address auto-increment.
- Exposes a fabric-side host port so logic can preload and observe register contents. Replaces fixed two-byte test responders.

Parameters:
- NUM_REGS, 22, number of 8-bit registers; legal range 2..256.
- SYNC_STAGES, 2, synchroniser depth for sclk_i/csn_i/mosi_i; minimum 2.
- SEQ_EN, 1, 1 = address auto-increments per data byte; 0 = address held for all bytes of a frame.
- OPC_BASE, 4'b0100, fixed upper nibble of the opcode byte.

Ports:
- clk  in  1  fabric clock; must be at least 8x the SCLK frequency.
- rst  in  1  asynchronous, active-high reset.
- sclk_i  in  1  SPI clock, asynchronous to clk.
- csn_i  in  1  chip select, active low.
- mosi_i  in  1  controller-to-target data.
- miso_o  out  1  target-to-controller data.
- miso_oe_o  out  1  MISO drive enable; high only during READ.
- hw_addr_i  in  3  strapped device address.
- host_addr_i  in  8  host register address.
- host_we_i  in  1  host write strobe.
- host_wdata_i  in  8  host write data.
- host_rdata_o  out  8  host read data, one cycle after host_addr_i.
- wr_stb_o  out  1  one-cycle pulse per completed SPI data-byte write.
- wr_addr_o  out  8  register address of that write.
- wr_data_o  out  8  data of that write.
- busy_o  out  1  high while CSN is low and the frame has been accepted.

Behaviour:
- Reset: miso_o=0, miso_oe_o=0, wr_stb_o=0, wr_addr_o=0, wr_data_o=0, host_rdata_o=0, busy_o=0. Registers 0x00/0x01 reset to 8'hFF; all others reset to 8'h00. State is IDLE.
- Reset asserted mid-frame: everything returns to reset values immediately; the partial frame is lost. After release, the block waits for CSN to go high before it accepts a new frame.
- Synchronise all three SPI inputs. Derive single-cycle sclk_rise/sclk_fall and csn_fall/csn_rise pulses from the synchronised signals.
- MOSI is sampled on sclk_rise, MSB first. MISO changes only on sclk_fall.
- States and transitions:
  - IDLE: on csn_fall go to OPCODE; bit counter = 7.
  - OPCODE: after 8 bits, if opc[7:4]==OPC_BASE (plus address match, see Optional Feature) go to ADDR; otherwise go to IGNORE. opc[0]=1 means read.
  - ADDR: after 8 bits, latch ptr. Go to WRITE if opc[0]=0; otherwise load shift_out=reg[ptr] and go to READ. miso_oe_o rises in the same cycle as the READ entry. miso_o shows bit7 at the next sclk_fall.
  - WRITE: on each 8th bit, if ptr<NUM_REGS write reg[ptr] and pulse wr_stb_o, wr_addr_o=ptr, wr_data_o=byte. If ptr>=NUM_REGS, drop the write and do not pulse. Then advance ptr.
  - READ: shift one bit per sclk_fall. At each byte boundary advance ptr and reload shift_out. An out-of-range ptr reads 8'h00.
  - IGNORE: miso_oe_o=0, busy_o=0; hold until csn_rise.
- Pointer advance: if SEQ_EN, ptr=(ptr==NUM_REGS-1)?0:ptr+1. If ptr>=NUM_REGS, ptr is held. If not SEQ_EN, ptr is unchanged.
- csn_rise in any state: go to IDLE, discard any partial byte, miso_oe_o=0, miso_o=0, busy_o=0.
- Host write and SPI write to the same register in the same cycle: SPI wins and the host write is lost. Host writes to out-of-range addresses are ignored.
- A READ frame samples register contents at each byte-boundary reload. A host write that lands mid-byte appears in the next byte.

Optional Feature:
- Macro: SPI_HW_ADDR_EN.
- Defined: opcode bits [3:1] must equal hw_addr_i, else the frame goes to IGNORE.
- Undefined: bits [3:1] are don't-care and hw_addr_i is unused; any opcode with the OPC_BASE upper nibble is accepted.

Decomposition:
- Package spi_sink_pkg holds:
  - enum spi_sink_state_t {IDLE, OPCODE, ADDR, WRITE, READ, IGNORE};
  - constants OPC_BASE_DEF, REG_IODIRA=8'h00, REG_IODIRB=8'h01, REG_GPIOA=8'h12, REG_GPIOB=8'h13.
- Sub-module spi_sync_edge: SYNC_STAGES-deep synchroniser plus rise/fall pulse detector; instantiated once per SPI input.

Test Plan:
- Reset, then host read of 0x00 and 0x05 -> 8'hFF and 8'h00. All outputs are at reset values.
- SPI write frame 8'h40,8'h12,8'hA5 -> single wr_stb_o pulse, wr_addr_o=8'h12, wr_data_o=8'hA5; host read of 0x12 returns 8'hA5.
- Host preloads 0x14=8'h3C and 0x15=8'hC3. SPI read frame 8'h41,8'h14, then 16 clocks -> MISO returns 8'h3C then 8'hC3 MSB first; miso_oe_o is high only during those 16 bits.
- SEQ_EN=1, NUM_REGS=22: write from addr 8'h15 with bytes 11,22 -> reg 0x15=8'h11 and reg 0x00=8'h22 (wrap).
- With SPI_HW_ADDR_EN and hw_addr_i=3'b010: opcode 8'h40 -> IGNORE, no wr_stb_o, miso_oe_o=0. Opcode 8'h44 -> accepted.
- CSN deasserted after 5 data bits of a write, and rst pulsed mid-read -> no register change; state IDLE; the next full frame succeeds.
